// File: rtl/pc_sequencer_if.sv
// Decode/stack-facing bundle for the PC sequencer.
// Master is the decode/stack side; slave is the sequencer itself.
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 12
);
  logic            cen;
  logic            jmp_i;
  logic            br_taken_i;
  logic            jsb_i;
  logic            ret_i;
  logic            reti_i;
  logic [PC_W-1:0] target_i;
  logic            int_req_i;
  logic [PC_W-1:0] stk_pc_i;
  logic            push_o;
  logic            pop_o;
  logic [PC_W-1:0] stk_pc_o;
  logic [PC_W-1:0] pc_o;
  logic            stall_o;
  logic            int_ack_o;
  logic            int_en_o;
  logic            ovf_o;
  logic            unf_o;

  modport master (
    output cen, jmp_i, br_taken_i, jsb_i, ret_i, reti_i, target_i, int_req_i, stk_pc_i,
    input  push_o, pop_o, stk_pc_o, pc_o, stall_o, int_ack_o, int_en_o, ovf_o, unf_o
  );

  modport slave (
    input  cen, jmp_i, br_taken_i, jsb_i, ret_i, reti_i, target_i, int_req_i, stk_pc_i,
    output push_o, pop_o, stk_pc_o, pc_o, stall_o, int_ack_o, int_en_o, ovf_o, unf_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the Gumnut core. Chooses the next PC each enabled cycle,
// drives the return-address stack and tracks its depth to flag overflow/underflow.
module pc_sequencer #(
  parameter int unsigned     PC_W       = 12,
  parameter int unsigned     DEPTH      = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(1)
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  localparam int unsigned   DW       = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

  // RetWaitI differs from RetWaitR only in re-enabling interrupts on exit
  typedef enum logic [1:0] {StRun, StRetWaitR, StRetWaitI} state_e;

  state_e          r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next, w_stk_val;
  logic [DW-1:0]   r_depth, w_depth_next;
  logic            r_int_en, w_int_en_next;
  logic            r_int_ack, w_int_take;
  logic            r_ovf, w_ovf_next;
  logic            r_unf, w_unf_next;
  logic            w_push, w_pop, w_en;

  // Registers: synchronous reset wins, otherwise advance only on enabled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StRun;
      r_pc      <= RESET_PC;
      r_depth   <= '0;
      r_int_en  <= 1'b1;
      r_int_ack <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else if (bus.cen) begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_depth   <= w_depth_next;
      r_int_en  <= w_int_en_next;
      r_int_ack <= w_int_take;
      r_ovf     <= w_ovf_next;
      r_unf     <= w_unf_next;
    end
  end

  // Next-state, next-PC and stack strobes (ungated; gating by cen/rst happens at the ports)
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_stk_val     = '0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_int_en_next = r_int_en;
    w_int_take    = 1'b0;
    w_depth_next  = r_depth;
    w_ovf_next    = r_ovf;
    w_unf_next    = r_unf;

    unique case (r_state)
      StRun: begin
        if (bus.reti_i) begin
          w_pop        = 1'b1;
          w_state_next = StRetWaitI;
        end else if (bus.ret_i) begin
          w_pop        = 1'b1;
          w_state_next = StRetWaitR;
        end else if (bus.jsb_i) begin
          w_push    = 1'b1;
          w_stk_val = r_pc + PC_W'(1);
          w_pc_next = bus.target_i;
        end else if (bus.jmp_i || bus.br_taken_i) begin
          w_pc_next = bus.target_i;
        end else if (bus.int_req_i && r_int_en) begin
          // Push the interrupted PC itself so that instruction re-executes on reti
          w_push        = 1'b1;
          w_stk_val     = r_pc;
          w_pc_next     = INT_VECTOR;
          w_int_en_next = 1'b0;
          w_int_take    = 1'b1;
        end else begin
          w_pc_next = r_pc + PC_W'(1);
        end
      end
      StRetWaitR: begin
        w_pc_next    = bus.stk_pc_i;
        w_state_next = StRun;
      end
      StRetWaitI: begin
        w_pc_next     = bus.stk_pc_i;
        w_int_en_next = 1'b1;
        w_state_next  = StRun;
      end
      default: w_state_next = StRun;
    endcase

    // Strobes are always issued; only the depth saturates and the sticky flags record it
    if (w_push) begin
      if (r_depth == DepthMax) w_ovf_next = 1'b1;
      else                     w_depth_next = r_depth + DW'(1);
    end
    if (w_pop) begin
      if (r_depth == '0) w_unf_next = 1'b1;
      else               w_depth_next = r_depth - DW'(1);
    end
  end

  assign w_en = bus.cen & ~rst;

  assign bus.push_o    = w_push & w_en;
  assign bus.pop_o     = w_pop & w_en;
  assign bus.stk_pc_o  = (w_push & w_en) ? w_stk_val : '0;
  assign bus.pc_o      = r_pc;
  assign bus.stall_o   = (r_state != StRun);
  assign bus.int_ack_o = r_int_ack;
  assign bus.int_en_o  = r_int_en;
  assign bus.ovf_o     = r_ovf;
  assign bus.unf_o     = r_unf;

endmodule
